// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - framed SPI command sequencer driving a register-file write stream
//
// Purpose:
//   Parses framed byte commands from the SPI slave into single, burst and
//   clear-all writes toward the parameter register file. It uses a one-entry
//   write buffer with a valid/ready handshake. It also flags bad-address,
//   overflow and inter-byte timeout errors.
//
// Ports:
//   i_clk         master clock
//   i_rst_n       asynchronous active-low reset
//   i_frame       frame active (SSEL asserted), clk-synchronous
//   i_byte        received byte, qualified by i_byte_valid
//   i_byte_valid  one-cycle strobe per received byte
//   o_wr_en       write request valid
//   o_wr_addr     write address
//   o_wr_data     write data
//   i_wr_ready    register file accepts (transfer on o_wr_en && i_wr_ready)
//   o_err         one-cycle pulses: [0] bad address, [1] overflow, [2] timeout
//   o_busy        state != IDLE or a write is pending
//   o_frame_cnt   (SPI_REG_CTRL_STATS_EN) commands leaving CMD other than to DISCARD
//   o_err_cnt     (SPI_REG_CTRL_STATS_EN) saturating count of error pulses
//
// Optional feature macro: SPI_REG_CTRL_STATS_EN

module spi_reg_ctrl #(
  parameter int NREGS   = 32,
  parameter int TIMEOUT = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_wr_en,
  output logic [5:0]  o_wr_addr,
  output logic [7:0]  o_wr_data,
  input  logic        i_wr_ready,
  output logic [2:0]  o_err,
`ifdef SPI_REG_CTRL_STATS_EN
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_err_cnt,
`endif
  output logic        o_busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_CLEAR   = 3'd3;
  localparam logic [2:0] ST_DISCARD = 3'd4;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_SINGLE = 2'b01;
  localparam logic [1:0] OP_BURST  = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  localparam logic [6:0]    LP_NREGS   = 7'(NREGS);
  localparam logic [5:0]    LP_LAST    = 6'(NREGS - 1);
  localparam logic [CW-1:0] LP_TIMEOUT = CW'(TIMEOUT);

  logic [2:0]    r_state;
  logic [1:0]    r_op;
  logic [5:0]    r_addr;
  logic [CW-1:0] r_cnt;
  logic          r_wr_en;
  logic [5:0]    r_wr_addr;
  logic [7:0]    r_wr_data;
  logic [2:0]    r_err;

  logic [2:0]    w_state_nxt;
  logic [1:0]    w_op_nxt;
  logic [5:0]    w_addr_nxt;
  logic [2:0]    w_err_nxt;
  logic          w_load;
  logic [7:0]    w_load_data;
  logic          w_cnt_tick;
  logic [CW-1:0] w_cnt_inc;
  logic          w_buf_free;
  logic [5:0]    w_addr_wrap;

  // The single buffer entry can take a new write if it is empty or is being
  // drained this very cycle.
  assign w_buf_free  = !r_wr_en || i_wr_ready;
  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_addr_wrap = (r_addr == LP_LAST) ? 6'd0 : r_addr + 6'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_addr_nxt  = r_addr;
    w_err_nxt   = 3'b000;
    w_load      = 1'b0;
    w_load_data = 8'h00;
    w_cnt_tick  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_frame) w_state_nxt = ST_CMD;
      end

      ST_CMD: begin
        if (!i_frame) begin
          w_state_nxt = ST_IDLE;
        end else if (i_byte_valid) begin
          w_op_nxt   = i_byte[7:6];
          w_addr_nxt = i_byte[5:0];
          if ((i_byte[7:6] == OP_SINGLE || i_byte[7:6] == OP_BURST) &&
              ({1'b0, i_byte[5:0]} >= LP_NREGS)) begin
            w_err_nxt[0] = 1'b1;
            w_state_nxt  = ST_DISCARD;
          end else begin
            case (i_byte[7:6])
              OP_NOP:   w_state_nxt = ST_DISCARD;
              OP_CLEAR: begin
                w_state_nxt = ST_CLEAR;
                w_addr_nxt  = 6'd0;
              end
              default:  w_state_nxt = ST_DATA;
            endcase
          end
        end else begin
          w_cnt_tick = 1'b1;
        end
      end

      ST_DATA: begin
        if (!i_frame) begin
          w_state_nxt = ST_IDLE;
        end else if (i_byte_valid) begin
          if (!w_buf_free) begin
            w_err_nxt[1] = 1'b1;
            w_state_nxt  = ST_DISCARD;
          end else begin
            w_load      = 1'b1;
            w_load_data = i_byte;
            if (r_op == OP_SINGLE) w_state_nxt = ST_DISCARD;
            else                   w_addr_nxt  = w_addr_wrap;
          end
        end else begin
          w_cnt_tick = 1'b1;
        end
      end

      // Runs to completion regardless of FRAME; r_addr doubles as the clear index.
      ST_CLEAR: begin
        if (w_buf_free) begin
          w_load = 1'b1;
          if (r_addr == LP_LAST) w_state_nxt = i_frame ? ST_DISCARD : ST_IDLE;
          else                   w_addr_nxt  = r_addr + 6'd1;
        end
      end

      ST_DISCARD: begin
        if (!i_frame) w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_cnt_tick && (w_cnt_inc == LP_TIMEOUT)) begin
      w_err_nxt[2] = 1'b1;
      w_state_nxt  = ST_DISCARD;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_NOP;
      r_addr    <= 6'd0;
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 6'd0;
      r_wr_data <= 8'h00;
      r_err     <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_addr  <= w_addr_nxt;
      r_err   <= w_err_nxt;

      if (i_byte_valid || (w_state_nxt != r_state)) r_cnt <= '0;
      else if (w_cnt_tick)                          r_cnt <= w_cnt_inc;

      if (w_load) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_addr;
        r_wr_data <= w_load_data;
      end else if (r_wr_en && i_wr_ready) begin
        r_wr_en <= 1'b0;
      end
    end
  end

`ifdef SPI_REG_CTRL_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_err_cnt;
  logic        w_frame_hit;

  assign w_frame_hit = (r_state == ST_CMD) && (w_state_nxt != ST_CMD) &&
                       (w_state_nxt != ST_DISCARD);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
    end else begin
      if (w_frame_hit) r_frame_cnt <= r_frame_cnt + 16'd1;
      if ((w_err_nxt != 3'b000) && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_err_cnt   = r_err_cnt;
`endif

  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_err     = r_err;
  assign o_busy    = (r_state != ST_IDLE) || r_wr_en;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - scoreboard testbench for spi_reg_ctrl

module tb_spi_reg_ctrl;

  localparam int TB_NREGS   = 32;
  localparam int TB_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       wr_ready;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] err;
  logic       busy;
`ifdef SPI_REG_CTRL_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
`endif

  int n_chk  = 0;
  int n_err  = 0;
  int n_xfer = 0;
  logic [13:0] sb_q[$];

  always #5 clk = ~clk;

  spi_reg_ctrl #(.NREGS(TB_NREGS), .TIMEOUT(TB_TIMEOUT)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame      (frame),
    .i_byte       (byte_in),
    .i_byte_valid (byte_valid),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .i_wr_ready   (wr_ready),
    .o_err        (err),
`ifdef SPI_REG_CTRL_STATS_EN
    .o_frame_cnt  (frame_cnt),
    .o_err_cnt    (err_cnt),
`endif
    .o_busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs only change 1ns after a rising edge, so what is seen here is what
  // the next rising edge will act on.
  always @(negedge clk) begin
    if (wr_en === 1'b1 && wr_ready === 1'b1) begin
      n_xfer++;
      if (sb_q.size() == 0) begin
        check_eq("xfer_unexpected", 32'(sb_q.size()), 32'd1);
      end else begin
        check_eq("xfer", 32'({wr_addr, wr_data}), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic frame_start();
    frame = 1'b1;
    tick();
  endtask

  task automatic frame_end();
    frame = 1'b0;
    tick();
    tick();
  endtask

  task automatic expect_wr(input logic [5:0] a, input logic [7:0] d);
    sb_q.push_back({a, d});
  endtask

  initial begin
    int x0;
    int k;
    rst_n      = 1'b0;
    frame      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    wr_ready   = 1'b1;
    repeat (3) tick();
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst_wr_data", 32'(wr_data), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // T1 single write
    x0 = n_xfer;
    frame_start();
    expect_wr(6'h05, 8'hA5);
    send_byte(8'h45);
    send_byte(8'hA5);
    check_eq("t1_wr_en_latency", 32'(wr_en), 32'd1);
    send_byte(8'h77);
    frame_end();
    check_eq("t1_err", 32'(err), 32'd0);
    check_eq("t1_busy", 32'(busy), 32'd0);
    check_eq("t1_nxfer", 32'(n_xfer - x0), 32'd1);
    check_eq("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // T2 burst with address wrap
    x0 = n_xfer;
    frame_start();
    send_byte(8'h9E);
    expect_wr(6'd30, 8'h11);
    send_byte(8'h11);
    expect_wr(6'd31, 8'h22);
    send_byte(8'h22);
    expect_wr(6'd0, 8'h33);
    send_byte(8'h33);
    frame_end();
    check_eq("t2_nxfer", 32'(n_xfer - x0), 32'd3);
    check_eq("t2_sb_empty", 32'(sb_q.size()), 32'd0);

    // T3 backpressure and overflow
    x0 = n_xfer;
    wr_ready = 1'b0;
    frame_start();
    send_byte(8'h80);
    expect_wr(6'd0, 8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    check_eq("t3_err_overflow", 32'(err), 32'd2);
    tick();
    check_eq("t3_err_pulse_len", 32'(err), 32'd0);
    check_eq("t3_hold_en", 32'(wr_en), 32'd1);
    check_eq("t3_hold_addr", 32'(wr_addr), 32'd0);
    check_eq("t3_hold_data", 32'(wr_data), 32'h01);
    send_byte(8'h03);
    frame_end();
    check_eq("t3_busy_pending", 32'(busy), 32'd1);
    check_eq("t3_hold_data2", 32'(wr_data), 32'h01);
    wr_ready = 1'b1;
    repeat (4) tick();
    check_eq("t3_nxfer", 32'(n_xfer - x0), 32'd1);
    check_eq("t3_wr_en_drop", 32'(wr_en), 32'd0);
    check_eq("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // T4a bad address
    x0 = n_xfer;
    frame_start();
    send_byte(8'h7F);
    check_eq("t4_err_badaddr", 32'(err), 32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    frame_end();
    check_eq("t4_badaddr_nxfer", 32'(n_xfer - x0), 32'd0);

    // T4b timeout after command byte
    frame_start();
    send_byte(8'h40);
    k = 0;
    while (k < TB_TIMEOUT + 5) begin
      tick();
      k++;
      if (err[2] === 1'b1) break;
    end
    check_eq("t4_timeout_cycle", 32'(k), 32'(TB_TIMEOUT));
    check_eq("t4_timeout_err", 32'(err), 32'd4);
    send_byte(8'h55);
    frame_end();
    check_eq("t4_timeout_nxfer", 32'(n_xfer - x0), 32'd0);

`ifdef SPI_REG_CTRL_STATS_EN
    check_eq("stats_frame_cnt", 32'(frame_cnt), 32'd4);
    check_eq("stats_err_cnt", 32'(err_cnt), 32'd3);
`endif

    // T5 clear-all surviving frame end, random backpressure
    x0 = n_xfer;
    for (int i = 0; i < TB_NREGS; i++) expect_wr(6'(i), 8'h00);
    frame_start();
    send_byte(8'hC0);
    frame = 1'b0;
    k = 0;
    while (k < 400 && (sb_q.size() != 0 || busy === 1'b1)) begin
      wr_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    wr_ready = 1'b1;
    check_eq("t5_sb_empty", 32'(sb_q.size()), 32'd0);
    check_eq("t5_nxfer", 32'(n_xfer - x0), 32'(TB_NREGS));
    check_eq("t5_idle", 32'(busy), 32'd0);

    // T6 reset while a write is pending
    x0 = n_xfer;
    wr_ready = 1'b0;
    frame_start();
    send_byte(8'h80);
    send_byte(8'h12);
    check_eq("t6_pending", 32'(wr_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_wr_en", 32'(wr_en), 32'd0);
    check_eq("t6_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("t6_wr_data", 32'(wr_data), 32'd0);
    check_eq("t6_err", 32'(err), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    frame    = 1'b0;
    wr_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check_eq("t6_nxfer", 32'(n_xfer - x0), 32'd0);
    check_eq("t6_wr_en_after", 32'(wr_en), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
